mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 98 +++++++++
 tb/tb_mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one request/acknowledge memory port between instruction fetch and data load/store.
// Data wins over fetch; each access ends with a one-cycle done pulse to its owner.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  localparam bit         TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);

  state_t     state_reg;
  logic [7:0] wait_cnt_reg;
  logic       timed_out;

  assign timed_out = TIMEOUT_EN && (wait_cnt_reg == TIMEOUT_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_rdata     <= '0;
      d_rdata      <= '0;
      if_done      <= 1'b0;
      d_done       <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Data first: the current instruction's load/store must retire before the next fetch.
          if (d_rd || d_wr) begin
            state_reg    <= DATA;
            mem_req      <= 1'b1;
            mem_we       <= d_wr;
            mem_addr     <= d_addr;
            mem_wdata    <= d_wdata;
            wait_cnt_reg <= '0;
          end else if (if_req) begin
            state_reg    <= FETCH;
            mem_req      <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= if_addr;
            mem_wdata    <= '0;
            wait_cnt_reg <= '0;
          end
        end
        FETCH, DATA: begin
          if (mem_ack || timed_out) begin
            mem_req   <= 1'b0;
            state_reg <= DONE;
            if (state_reg == FETCH) begin
              if_done  <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              d_done <= 1'b1;
              if (!mem_we) d_rdata <= mem_ack ? mem_rdata : '0;
            end
            if (!mem_ack) bus_err <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        // One dead cycle lets the requester drop or advance its request before re-arbitration.
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, priority, wait-state store, timeout,
// asynchronous reset mid-access and back-to-back fetches.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_err;

  int n_checks = 0;
  int n_pass   = 0;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_done(if_done),
    .d_rd(d_rd),
    .d_wr(d_wr),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_done(d_done),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int grants;
    int last;

    rst = 1'b0; if_req = 1'b0; if_addr = '0; d_rd = 1'b0; d_wr = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_if_done", 32'(if_done), 32'd0);
    check("rst_d_done", 32'(d_done), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    rst = 1'b1;

    // Basic zero-wait fetch
    if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'h00500093;
    tick();
    check("fetch_req", 32'(mem_req), 32'd1);
    check("fetch_we", 32'(mem_we), 32'd0);
    check("fetch_addr", mem_addr, 32'h10);
    check("fetch_done_early", 32'(if_done), 32'd0);
    mem_ack = 1'b1;
    tick();
    check("fetch_req_drop", 32'(mem_req), 32'd0);
    check("fetch_done", 32'(if_done), 32'd1);
    check("fetch_rdata", if_rdata, 32'h00500093);
    check("fetch_no_d_done", 32'(d_done), 32'd0);
    mem_ack = 1'b0; if_req = 1'b0;
    tick();
    check("fetch_done_1cyc", 32'(if_done), 32'd0);
    tick();
    check("fetch_no_regrant", 32'(mem_req), 32'd0);

    // Data beats fetch when both request together
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    if_req = 1'b1; if_addr = 32'h20; d_rd = 1'b1; d_addr = 32'h200;
    tick();
    check("prio_req", 32'(mem_req), 32'd1);
    check("prio_addr", mem_addr, 32'h200);
    check("prio_we", 32'(mem_we), 32'd0);
    tick();
    check("prio_d_done", 32'(d_done), 32'd1);
    check("prio_if_done", 32'(if_done), 32'd0);
    check("prio_d_rdata", d_rdata, 32'h11112222);
    d_rd = 1'b0; mem_rdata = 32'h33334444;
    tick();
    check("prio_gap", 32'(mem_req), 32'd0);
    check("prio_d_done_1cyc", 32'(d_done), 32'd0);
    tick();
    check("prio_fetch_req", 32'(mem_req), 32'd1);
    check("prio_fetch_addr", mem_addr, 32'h20);
    tick();
    check("prio_fetch_done", 32'(if_done), 32'd1);
    check("prio_no_d_regrant", 32'(d_done), 32'd0);
    check("prio_if_rdata", if_rdata, 32'h33334444);
    if_req = 1'b0; mem_ack = 1'b0;
    tick();
    check("prio_idle", 32'(mem_req), 32'd0);

    // Store with four wait states; request inputs change mid-access and must be ignored
    d_wr = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFEF00D;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("st_req", 32'(mem_req), 32'd1);
      check("st_we", 32'(mem_we), 32'd1);
      check("st_addr", mem_addr, 32'h40);
      check("st_wdata", mem_wdata, 32'hCAFEF00D);
      check("st_no_done", 32'(d_done), 32'd0);
      if (i == 0) begin
        d_addr = 32'h44; d_wdata = 32'hDEADBEEF;
      end
      if (i == 4) mem_ack = 1'b1;
      tick();
    end
    check("st_done", 32'(d_done), 32'd1);
    check("st_req_drop", 32'(mem_req), 32'd0);
    check("st_d_rdata_kept", d_rdata, 32'h11112222);
    check("st_no_err", 32'(bus_err), 32'd0);
    mem_ack = 1'b0; d_wr = 1'b0;
    tick();
    check("st_done_1cyc", 32'(d_done), 32'd0);

    // Read that is never acknowledged: aborts after TIMEOUT_CYCLES+1 cycles
    d_rd = 1'b1; d_addr = 32'h80; mem_rdata = 32'h99999999;
    tick();
    check("to_req", 32'(mem_req), 32'd1);
    check("to_err_before", 32'(bus_err), 32'd0);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!mem_req) break;
      cnt++;
    end
    check("to_req_cycles", 32'(cnt), 32'd9);
    check("to_d_done", 32'(d_done), 32'd1);
    check("to_d_rdata", d_rdata, 32'h0);
    check("to_bus_err", 32'(bus_err), 32'd1);
    d_rd = 1'b0;
    tick();
    check("to_done_1cyc", 32'(d_done), 32'd0);
    if_req = 1'b1; if_addr = 32'h30; mem_ack = 1'b1; mem_rdata = 32'h00000055;
    tick();
    tick();
    check("to_after_done", 32'(if_done), 32'd1);
    check("to_after_rdata", if_rdata, 32'h00000055);
    check("to_err_sticky", 32'(bus_err), 32'd1);
    if_req = 1'b0; mem_ack = 1'b0;
    tick();

    // Asynchronous reset while a data read is outstanding
    d_rd = 1'b1; d_addr = 32'h90;
    tick();
    check("rm_req_before", 32'(mem_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rm_req_async", 32'(mem_req), 32'd0);
    check("rm_d_done_async", 32'(d_done), 32'd0);
    check("rm_err_async", 32'(bus_err), 32'd0);
    check("rm_addr_async", mem_addr, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    check("rm_regrant_req", 32'(mem_req), 32'd1);
    check("rm_regrant_addr", mem_addr, 32'h90);
    mem_ack = 1'b1; mem_rdata = 32'h00000077;
    tick();
    check("rm_d_done", 32'(d_done), 32'd1);
    check("rm_d_rdata", d_rdata, 32'h00000077);
    d_rd = 1'b0; mem_ack = 1'b0;
    tick();
    tick();

    // Back-to-back fetches with address advanced on every if_done
    if_req = 1'b1; if_addr = 32'h100; mem_ack = 1'b1; mem_rdata = 32'h000000AA;
    grants = 0; last = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick();
      if (mem_req) begin
        check("b2b_addr", mem_addr, 32'h100 + 32'(4 * grants));
        if (grants > 0) check("b2b_spacing", 32'(cyc - last), 32'd3);
        grants++;
        last = cyc;
      end
      if (if_done) if_addr = if_addr + 32'd4;
    end
    check("b2b_grants", 32'(grants), 32'd4);
    if_req = 1'b0; mem_ack = 1'b0;
    tick();
    tick();
    check("b2b_idle", 32'(mem_req), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
